// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I data-memory access stage. Accepts one load/store at a
//            time, rejects illegal or misaligned requests, drives a word-wide
//            memory port with byte enables and a request/ack handshake, and
//            returns an extended load result or store completion as a
//            one-cycle response pulse. A timeout aborts an unanswered access.
// Ports    : i_clk, i_reset_n            - clock, async active-low reset
//            i_request_valid/o_request_ready, i_write, i_funct3, i_address,
//            i_store_data                - request from execute stage
//            o_response_valid, o_load_data, o_error
//                                        - completion back to the core
//            o_mem_request, o_mem_write, o_mem_address, o_mem_write_data,
//            o_mem_byte_enable, i_mem_ack, i_mem_read_data
//                                        - data memory port
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_request_valid,
  output logic        o_request_ready,
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_address,
  input  logic [31:0] i_store_data,
  output logic        o_response_valid,
  output logic [31:0] o_load_data,
  output logic        o_error,
  output logic        o_mem_request,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic [3:0]  o_mem_byte_enable,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_read_data
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  // For TIMEOUT_CYCLES == 0 this wraps, but the compare is disabled then.
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

  logic [1:0]  state;
  logic [2:0]  funct3;
  logic        write;
  logic [1:0]  addr_lo;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  byte_enable;
  logic [31:0] counter;
  logic [31:0] load_data;
  logic        error;

  logic        bad_request;
  logic [3:0]  lane_enable;
  logic [31:0] lane_write_data;
  logic [31:0] read_shifted;
  logic [31:0] load_extended;
  logic        in_access;

  // Request decode: legality, alignment and lane placement from raw inputs.
  always_comb begin
    bad_request     = 1'b0;
    lane_enable     = 4'b0000;
    lane_write_data = i_store_data;
    case (i_funct3)
      3'b000, 3'b100: begin
        lane_enable     = 4'b0001 << i_address[1:0];
        lane_write_data = {4{i_store_data[7:0]}};
        bad_request     = i_funct3[2] & i_write;
      end
      3'b001, 3'b101: begin
        lane_enable     = 4'b0011 << i_address[1:0];
        lane_write_data = {2{i_store_data[15:0]}};
        bad_request     = i_address[0] | (i_funct3[2] & i_write);
      end
      3'b010: begin
        lane_enable = 4'b1111;
        bad_request = (i_address[1:0] != 2'b00);
      end
      default: bad_request = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0; W accesses are aligned so k = 0.
  assign read_shifted = i_mem_read_data >> {addr_lo, 3'b000};

  always_comb begin
    case (funct3)
      3'b000:  load_extended = {{24{read_shifted[7]}}, read_shifted[7:0]};
      3'b100:  load_extended = {24'b0, read_shifted[7:0]};
      3'b001:  load_extended = {{16{read_shifted[15]}}, read_shifted[15:0]};
      3'b101:  load_extended = {16'b0, read_shifted[15:0]};
      default: load_extended = read_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      funct3         <= 3'b000;
      write          <= 1'b0;
      addr_lo        <= 2'b00;
      mem_address    <= 32'b0;
      mem_write_data <= 32'b0;
      byte_enable    <= 4'b0000;
      counter        <= 32'b0;
      load_data      <= 32'b0;
      error          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_request_valid) begin
            funct3         <= i_funct3;
            write          <= i_write;
            addr_lo        <= i_address[1:0];
            mem_address    <= {i_address[31:2], 2'b00};
            mem_write_data <= lane_write_data;
            byte_enable    <= lane_enable;
            counter        <= 32'b0;
            if (bad_request) begin
              load_data <= 32'b0;
              error     <= 1'b1;
              state     <= RESPOND;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority, so an ack on the final timeout cycle succeeds.
          if (i_mem_ack) begin
            load_data <= write ? 32'b0 : load_extended;
            error     <= 1'b0;
            state     <= RESPOND;
          end else if ((TIMEOUT_CYCLES != 0) && (counter == TIMEOUT_LAST)) begin
            load_data <= 32'b0;
            error     <= 1'b1;
            state     <= RESPOND;
          end else begin
            counter <= counter + 32'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory outputs derive from state so an async reset drops them at once.
  assign in_access         = (state == ACCESS);
  assign o_request_ready   = (state == IDLE);
  assign o_response_valid  = (state == RESPOND);
  assign o_load_data       = load_data;
  assign o_error           = error;
  assign o_mem_request     = in_access;
  assign o_mem_write       = in_access & write;
  assign o_mem_address     = in_access ? mem_address    : 32'b0;
  assign o_mem_write_data  = in_access ? mem_write_data : 32'b0;
  assign o_mem_byte_enable = in_access ? byte_enable    : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit (timeout 4).
//            Expected responses are queued when a request is issued and
//            popped when the unit raises o_response_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_request_valid;
  logic        o_request_ready;
  logic        i_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_address;
  logic [31:0] i_store_data;
  logic        o_response_valid;
  logic [31:0] o_load_data;
  logic        o_error;
  logic        o_mem_request;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_byte_enable;
  logic        i_mem_ack;
  logic [31:0] i_mem_read_data;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk             (i_clk),
    .i_reset_n         (i_reset_n),
    .i_request_valid   (i_request_valid),
    .o_request_ready   (o_request_ready),
    .i_write           (i_write),
    .i_funct3          (i_funct3),
    .i_address         (i_address),
    .i_store_data      (i_store_data),
    .o_response_valid  (o_response_valid),
    .o_load_data       (o_load_data),
    .o_error           (o_error),
    .o_mem_request     (o_mem_request),
    .o_mem_write       (o_mem_write),
    .o_mem_address     (o_mem_address),
    .o_mem_write_data  (o_mem_write_data),
    .o_mem_byte_enable (o_mem_byte_enable),
    .i_mem_ack         (i_mem_ack),
    .i_mem_read_data   (i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // waits < 0 means the memory never acknowledges.
  task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input int waits, input logic [31:0] rdata,
                         input logic exp_memreq, input logic [31:0] exp_maddr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_data, input logic exp_err,
                         input int exp_lat);
    int    c;
    bit    got;
    resp_t r;
    check({tag, " ready"}, {31'b0, o_request_ready}, 32'd1);
    sb.push_back('{data: exp_data, err: exp_err});
    i_request_valid = 1'b1;
    i_write         = wr;
    i_funct3        = f3;
    i_address       = addr;
    i_store_data    = sd;
    step();
    i_request_valid = 1'b0;
    c   = 1;
    got = 1'b0;
    while (c <= 40) begin
      if (o_response_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      check({tag, " mem_request"}, {31'b0, o_mem_request}, {31'b0, exp_memreq});
      if (exp_memreq) begin
        check({tag, " mem_address"}, o_mem_address, exp_maddr);
        check({tag, " byte_enable"}, {28'b0, o_mem_byte_enable}, {28'b0, exp_be});
        check({tag, " mem_write"}, {31'b0, o_mem_write}, {31'b0, wr});
        if (wr) check({tag, " mem_write_data"}, o_mem_write_data, exp_wd);
      end
      if (waits >= 0 && c == 1 + waits) begin
        i_mem_ack       = 1'b1;
        i_mem_read_data = rdata;
      end
      step();
      i_mem_ack = 1'b0;
      c++;
    end
    compared++;
    assert (got) else begin
      mismatched++;
      $error("FAIL %s response_timeout: observed none expected response within 40 cycles", tag);
    end
    if (got) begin
      check({tag, " latency"}, c, exp_lat);
      check({tag, " mem_request_at_resp"}, {31'b0, o_mem_request}, 32'd0);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        check({tag, " load_data"}, o_load_data, r.data);
        check({tag, " error"}, {31'b0, o_error}, {31'b0, r.err});
      end
      step();
      check({tag, " pulse_one_cycle"}, {31'b0, o_response_valid}, 32'd0);
      check({tag, " ready_after"}, {31'b0, o_request_ready}, 32'd1);
    end
  endtask

  initial begin
    i_reset_n       = 1'b0;
    i_request_valid = 1'b0;
    i_write         = 1'b0;
    i_funct3        = 3'b000;
    i_address       = 32'b0;
    i_store_data    = 32'b0;
    i_mem_ack       = 1'b0;
    i_mem_read_data = 32'b0;
    step();
    step();
    check("rst ready", {31'b0, o_request_ready}, 32'd1);
    check("rst response_valid", {31'b0, o_response_valid}, 32'd0);
    check("rst mem_request", {31'b0, o_mem_request}, 32'd0);
    check("rst load_data", o_load_data, 32'd0);
    check("rst error", {31'b0, o_error}, 32'd0);
    check("rst byte_enable", {28'b0, o_mem_byte_enable}, 32'd0);
    i_reset_n = 1'b1;
    step();

    // tag wr f3 addr sd waits rdata memreq maddr be wd data err lat
    run_req("LW",   1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 4);
    run_req("LB",   1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    run_req("LBU",  1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF1234, 1'b1, 32'h100, 4'b1000, 32'h0, 32'h00000080, 1'b0, 2);
    run_req("LH",   1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234, 1'b1, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    run_req("LHU",  1'b0, 3'b101, 32'h102, 32'h0, 1, 32'h80FF1234, 1'b1, 32'h100, 4'b1100, 32'h0, 32'h000080FF, 1'b0, 3);
    run_req("LB0",  1'b0, 3'b000, 32'h200, 32'h0, 0, 32'h123456F0, 1'b1, 32'h200, 4'b0001, 32'h0, 32'hFFFFFFF0, 1'b0, 2);
    run_req("SB",   1'b1, 3'b000, 32'h201, 32'h000000A5, 1, 32'hFFFFFFFF, 1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 3);
    run_req("SH",   1'b1, 3'b001, 32'h202, 32'hABCD1234, 0, 32'hFFFFFFFF, 1'b1, 32'h200, 4'b1100, 32'h12341234, 32'h0, 1'b0, 2);
    // Ack on the last timeout cycle still succeeds.
    run_req("SW_edge", 1'b1, 3'b010, 32'h10, 32'h11223344, 3, 32'h0, 1'b1, 32'h10, 4'b1111, 32'h11223344, 32'h0, 1'b0, 5);
    run_req("LW_mis", 1'b0, 3'b010, 32'h102, 32'h0, -1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_req("SH_mis", 1'b1, 3'b001, 32'h101, 32'h0, -1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_req("F3_011", 1'b0, 3'b011, 32'h0, 32'h0, -1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_req("SBU_ill", 1'b1, 3'b100, 32'h0, 32'h0, -1, 32'h0, 1'b0, 32'h0, 4'b0, 32'h0, 32'h0, 1'b1, 1);
    run_req("LW_ok2", 1'b0, 3'b010, 32'h8, 32'h0, 0, 32'hCAFEF00D, 1'b1, 32'h8, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 2);
    run_req("TMO",  1'b0, 3'b010, 32'h300, 32'h0, -1, 32'h0, 1'b1, 32'h300, 4'b1111, 32'h0, 32'h0, 1'b1, 5);
    run_req("after_TMO", 1'b0, 3'b100, 32'h301, 32'h0, 0, 32'h0000C300, 1'b1, 32'h300, 4'b0010, 32'h0, 32'h000000C3, 1'b0, 2);

    // Asynchronous reset during ACCESS.
    i_request_valid = 1'b1;
    i_write         = 1'b0;
    i_funct3        = 3'b010;
    i_address       = 32'h400;
    step();
    i_request_valid = 1'b0;
    check("arst pre mem_request", {31'b0, o_mem_request}, 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("arst mem_request_drop", {31'b0, o_mem_request}, 32'd0);
    check("arst ready", {31'b0, o_request_ready}, 32'd1);
    step();
    i_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("arst no_response", {31'b0, o_response_valid}, 32'd0);
    end
    check("arst ready_after", {31'b0, o_request_ready}, 32'd1);

    // Stray ack in IDLE.
    i_mem_ack       = 1'b1;
    i_mem_read_data = 32'h55555555;
    step();
    i_mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_ack no_response", {31'b0, o_response_valid}, 32'd0);
      step();
    end
    check("stray_ack ready", {31'b0, o_request_ready}, 32'd1);
    run_req("post_rst", 1'b0, 3'b001, 32'h500, 32'h0, 0, 32'h00007FFE, 1'b1, 32'h500, 4'b0011, 32'h0, 32'h00007FFE, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
